rc_pulse_decoder: RTL and testbench
===================================

Name: rc_pulse_decoder

Overview:
- Measures servo-style PWM pulses from an RC receiver channel, i.e. the receive end of the pulse format our servo PWM generators drive.
- Reports pulse high-time and frame period in microseconds, plus validity and timeout status.
- Sits as an Avalon-MM slave component in the Qsys system; the pulse pin is exported as a conduit import.

Parameters:
- CLK_HZ, 50000000, input clock frequency; microsecond tick divider = CLK_HZ/1000000.
- MIN_US, 800, shortest high-time accepted as valid.
- MAX_US, 2200, longest high-time accepted as valid.
- TIMEOUT_US, 50000, interval with no pulse_in edge before the signal is declared lost.
- CNT_W, 16, width of the microsecond counters and result registers.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- pulse_in  in  1  asynchronous RC pulse pin (conduit import).
- avs_address  in  2  register select.
- avs_read  in  1  read strobe.
- avs_readdata  out  32  read data, registered, read latency 1.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.

Behaviour:
Reset and input path:
- Reset: all state cleared.
  - avs_readdata = 0, width_us = 0, period_us = 0, status = 0.
  - FSM enters WAIT_RISE; prescaler and counters = 0.
- pulse_in passes through a 2-FF synchroniser, then a registered edge detector.
- An edge is acted on 3 clk cycles after the pin transitions.

Counting:
- Prescaler wraps at CLK_HZ/1000000-1 and emits a 1-cycle us_tick.
- hi_cnt and per_cnt are CNT_W wide, increment on us_tick, and saturate at 2^CNT_W-1 (no wrap).
- hi_cnt is reset to 0 by a rising edge; per_cnt is reset to 0 by a rising edge.
- idle_cnt is reset by any edge.

FSM states: WAIT_RISE, HIGH, LOW.
- WAIT_RISE: a partial pulse present at reset or after a timeout is never measured.
  - Rising edge -> HIGH; clear hi_cnt and per_cnt.
  - Period is not latched on this first edge.
- HIGH, on falling edge -> LOW.
  - If MIN_US <= hi_cnt <= MAX_US: width_us <= hi_cnt, set valid.
  - Otherwise: width_us is unchanged, set sticky range_err, clear valid.
- LOW, on rising edge -> HIGH.
  - period_us <= per_cnt (saturated value if overflowed); clear hi_cnt and per_cnt.
- Timeout, any state: idle_cnt reaches TIMEOUT_US -> WAIT_RISE.
  - Clear valid; set sticky timeout.
  - width_us and period_us hold their last values.
- Precedence: edge and timeout in the same cycle -> the edge wins.
- Measurement resolution is ±1 us, because the prescaler phase is not reset on an edge.

Register map (reads return 0 in unused bits; registered, data valid the cycle after avs_read):
- 0: width_us, read-only.
- 1: period_us, read-only.
- 2: status.
  - bit0 valid (RO).
  - bit1 timeout (sticky, W1C).
  - bit2 range_err (sticky, W1C).
  - bits[4:3] FSM state (RO): 0 WAIT_RISE, 1 HIGH, 2 LOW.
- 3: reads CLK_HZ/1000000; writes ignored.
- Writes to addresses 0, 1 and 3 are ignored.
- W1C versus a same-cycle set: the set wins.

Reset mid-pulse: asynchronous return to the reset state; the next measurement starts from WAIT_RISE.

Decomposition:
- Shared package rc_pulse_pkg holds:
  - state enum (WAIT_RISE/HIGH/LOW);
  - register address constants (ADDR_WIDTH=0, ADDR_PERIOD=1, ADDR_STATUS=2, ADDR_INFO=3);
  - status bit indices.
- Sub-module us_tick_gen: prescaler emitting us_tick. It is reusable by the ultrasonic and hall-sensor blocks.
- Synchroniser and edge detect stay inline.

Test Plan:
- Reset, then 1500 us high / 20000 us period pulse train for 3 frames -> after frame 2:
  - reg0 = 1500 ±1;
  - reg1 = 20000 ±1;
  - status valid = 1, timeout = 0, range_err = 0.
- Release reset while pulse_in is already high (400 us remaining), then a normal 1000 us pulse ->
  - the partial pulse is ignored (range_err stays 0);
  - reg0 = 1000 ±1 after the second pulse.
- 600 us pulse after a valid 1500 us pulse ->
  - reg0 stays 1500;
  - status valid = 0, range_err = 1;
  - write 0x4 to addr 2 -> range_err = 0.
- Stop pulses (hold low) for 50001 us after valid frames ->
  - status timeout = 1, valid = 0, state = WAIT_RISE;
  - reg0 and reg1 keep their last values;
  - resume pulses -> valid = 1 after the second rising edge.
- Period of 70000 us with 1500 us high and TIMEOUT_US set to 100000 ->
  - reg1 = 65535 (saturated);
  - reg0 = 1500.
- Assert reset_n low mid-HIGH at an arbitrary phase -> all registers read 0 on the next read, state = WAIT_RISE.

Source files
------------

// File: rtl/rc_pulse_pkg.sv
// Shared definitions for the RC pulse decoder.
// - state_t      : measurement FSM states, encoded as read back in status[4:3]
// - ADDR_*       : Avalon-MM register addresses
// - STAT_*       : bit positions inside the status register
package rc_pulse_pkg;

    typedef enum logic [1:0] {
        WAIT_RISE = 2'd0,
        HIGH      = 2'd1,
        LOW       = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_WIDTH  = 2'd0;
    localparam logic [1:0] ADDR_PERIOD = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_INFO   = 2'd3;

    localparam int unsigned STAT_VALID    = 0;
    localparam int unsigned STAT_TIMEOUT  = 1;
    localparam int unsigned STAT_RANGE    = 2;
    localparam int unsigned STAT_STATE_LO = 3;

endpackage

// File: rtl/us_tick_gen.sv
// Prescaler producing a one-cycle tick every DIV clock cycles.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   us_tick  out  high for one cycle when the prescaler wraps
module us_tick_gen #(
    parameter int unsigned DIV = 50
) (
    input  logic clk,
    input  logic reset_n,
    output logic us_tick
);

    localparam int unsigned    PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  LAST = PW'(DIV - 1);

    logic [PW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PW'(1);
        end
    end

    assign us_tick = (cnt == LAST);

endmodule

// File: rtl/rc_pulse_decoder.sv
// Servo-style PWM pulse decoder with an Avalon-MM slave register interface.
// Measures high-time and rising-to-rising period in microseconds and flags
// out-of-range pulses and loss of signal.
// Ports:
//   clk            in   system clock
//   reset_n        in   asynchronous active-low reset
//   pulse_in       in   asynchronous RC pulse pin
//   avs_address    in   register select (0 width, 1 period, 2 status, 3 info)
//   avs_read       in   read strobe
//   avs_readdata   out  registered read data, latency 1
//   avs_write      in   write strobe
//   avs_writedata  in   write data (only status W1C bits are used)
module rc_pulse_decoder #(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned MIN_US     = 800,
    parameter int unsigned MAX_US     = 2200,
    parameter int unsigned TIMEOUT_US = 50000,
    parameter int unsigned CNT_W      = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pulse_in,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata
);
    import rc_pulse_pkg::*;

    localparam int unsigned       DIV       = CLK_HZ / 1000000;
    localparam int unsigned       IW        = $clog2(TIMEOUT_US + 1);
    localparam logic [CNT_W-1:0]  MIN_C     = CNT_W'(MIN_US);
    localparam logic [CNT_W-1:0]  MAX_C     = CNT_W'(MAX_US);
    localparam logic [IW-1:0]     IDLE_LAST = IW'(TIMEOUT_US - 1);
    localparam logic [IW-1:0]     IDLE_TOP  = IW'(TIMEOUT_US);

    logic us_tick;

    us_tick_gen #(.DIV(DIV)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .us_tick (us_tick)
    );

    // Synchroniser plus registered edge detector. Edges are suppressed until
    // the pipeline holds real pin samples, so a pin already high at reset
    // release is not mistaken for a rising edge.
    logic       sync1, sync2, sync3;
    logic [1:0] fill;
    logic       rise, fall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
            fill  <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= pulse_in;
            sync2 <= sync1;
            sync3 <= sync2;
            if (fill != 2'd3) fill <= fill + 2'd1;
            rise  <= (fill == 2'd3) && sync2 && !sync3;
            fall  <= (fill == 2'd3) && !sync2 && sync3;
        end
    end

    // Microsecond counters; hi/per saturate, idle stops at the timeout value
    // so the timeout fires once per idle interval.
    logic [CNT_W-1:0] hi_cnt, per_cnt;
    logic [IW-1:0]    idle_cnt;
    logic             timeout_hit;

    assign timeout_hit = us_tick && (idle_cnt == IDLE_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi_cnt   <= '0;
            per_cnt  <= '0;
            idle_cnt <= '0;
        end else begin
            if (rise) begin
                hi_cnt  <= '0;
                per_cnt <= '0;
            end else if (us_tick) begin
                if (hi_cnt  != '1) hi_cnt  <= hi_cnt  + CNT_W'(1);
                if (per_cnt != '1) per_cnt <= per_cnt + CNT_W'(1);
            end
            if (rise || fall) begin
                idle_cnt <= '0;
            end else if (us_tick && idle_cnt != IDLE_TOP) begin
                idle_cnt <= idle_cnt + IW'(1);
            end
        end
    end

    // Measurement FSM
    state_t state_q, state_d;
    logic   latch_width, latch_period, set_valid, set_range, set_timeout;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= WAIT_RISE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        latch_width  = 1'b0;
        latch_period = 1'b0;
        set_valid    = 1'b0;
        set_range    = 1'b0;
        set_timeout  = 1'b0;
        case (state_q)
            WAIT_RISE: if (rise) state_d = HIGH;
            HIGH: if (fall) begin
                state_d = LOW;
                if (hi_cnt >= MIN_C && hi_cnt <= MAX_C) begin
                    latch_width = 1'b1;
                    set_valid   = 1'b1;
                end else begin
                    set_range   = 1'b1;
                end
            end
            LOW: if (rise) begin
                state_d      = HIGH;
                latch_period = 1'b1;
            end
            default: state_d = WAIT_RISE;
        endcase
        // An edge in the same cycle overrides the timeout.
        if (timeout_hit && !rise && !fall) begin
            state_d     = WAIT_RISE;
            set_timeout = 1'b1;
        end
    end

    // Result and status registers
    logic [CNT_W-1:0] width_q, period_q;
    logic             valid_q, timeout_q, range_q;
    logic             status_wr;

    assign status_wr = avs_write && (avs_address == ADDR_STATUS);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            width_q   <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            range_q   <= 1'b0;
        end else begin
            if (latch_width)  width_q  <= hi_cnt;
            if (latch_period) period_q <= per_cnt;
            if (set_valid)                     valid_q <= 1'b1;
            else if (set_range || set_timeout) valid_q <= 1'b0;
            if (set_timeout)                                   timeout_q <= 1'b1;
            else if (status_wr && avs_writedata[STAT_TIMEOUT]) timeout_q <= 1'b0;
            if (set_range)                                     range_q   <= 1'b1;
            else if (status_wr && avs_writedata[STAT_RANGE])   range_q   <= 1'b0;
        end
    end

    logic [31:0] status_word;

    always_comb begin
        status_word                       = '0;
        status_word[STAT_VALID]           = valid_q;
        status_word[STAT_TIMEOUT]         = timeout_q;
        status_word[STAT_RANGE]           = range_q;
        status_word[STAT_STATE_LO +: 2]   = state_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avs_readdata <= '0;
        end else if (avs_read) begin
            case (avs_address)
                ADDR_WIDTH:  avs_readdata <= 32'(width_q);
                ADDR_PERIOD: avs_readdata <= 32'(period_q);
                ADDR_STATUS: avs_readdata <= status_word;
                default:     avs_readdata <= 32'(DIV);
            endcase
        end
    end

    logic unused;
    assign unused = ^{avs_writedata[31:3], avs_writedata[0]};

endmodule

// File: tb/tb_rc_pulse_decoder.sv
// Directed bench for rc_pulse_decoder, scaled down (2 MHz clock, 12-bit
// counters, 80..220 us window, 5000 us timeout) to keep runs short.
module tb_rc_pulse_decoder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pulse_in;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        avs_write;
    logic [31:0] avs_writedata;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned cyc    = 0;
    int unsigned t_rise = 0;
    int unsigned t_fall = 0;
    logic [31:0] d;

    rc_pulse_decoder #(
        .CLK_HZ     (2000000),
        .MIN_US     (80),
        .MAX_US     (220),
        .TIMEOUT_US (5000),
        .CNT_W      (12)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pulse_in      (pulse_in),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_readdata  (avs_readdata),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_near(input string tag, input logic [31:0] obs, input int unsigned exp);
        logic ok;
        ok = (obs + 32'd1 >= exp) && (obs <= exp + 32'd1);
        checks++;
        assert (ok === 1'b1) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d+-1", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] data);
        @(negedge clk);
        avs_address = a;
        avs_read    = 1'b1;
        @(negedge clk);
        avs_read    = 1'b0;
        data        = avs_readdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] data);
        @(negedge clk);
        avs_address   = a;
        avs_writedata = data;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_write     = 1'b0;
    endtask

    task automatic wait_us(input int unsigned us);
        repeat (2 * us) @(negedge clk);
    endtask

    task automatic wait_until(input int unsigned ref_cyc, input int unsigned us);
        while (cyc < ref_cyc + 2 * us) @(negedge clk);
    endtask

    task automatic rise_now();
        @(negedge clk);
        pulse_in = 1'b1;
        t_rise   = cyc;
    endtask

    task automatic rise_at(input int unsigned us);
        wait_until(t_rise, us);
        pulse_in = 1'b1;
        t_rise   = cyc;
    endtask

    task automatic fall_at(input int unsigned us);
        wait_until(t_rise, us);
        pulse_in = 1'b0;
        t_fall   = cyc;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; pulse_in = 1'b0;
        avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Reset state
        rd(2'd0, d); chk("rst_width", d, 32'd0);
        rd(2'd1, d); chk("rst_period", d, 32'd0);
        rd(2'd2, d); chk("rst_status", d, 32'd0);
        rd(2'd3, d); chk("info", d, 32'd2);
        wait_us(2);

        // Three frames, 150 us high, 2000 us period
        rise_now();
        fall_at(150); rise_at(2000);
        fall_at(150); rise_at(2000);
        fall_at(150); wait_us(10);
        rd(2'd0, d); chk_near("t1_width", d, 150);
        rd(2'd1, d); chk_near("t1_period", d, 2000);
        rd(2'd2, d); chk("t1_status", d, 32'h11);

        // Writes to read-only addresses are ignored
        wr(2'd0, 32'hFFF); wr(2'd3, 32'h55);
        rd(2'd0, d); chk_near("ro_width", d, 150);
        rd(2'd3, d); chk("ro_info", d, 32'd2);

        // Too-short pulse, then W1C of range_err
        rise_at(2000); fall_at(60); wait_us(10);
        rd(2'd0, d); chk_near("short_width", d, 150);
        rd(2'd2, d); chk("short_status", d, 32'h14);
        wr(2'd2, 32'h4);
        rd(2'd2, d); chk("w1c_range", d, 32'h10);

        // One more valid frame, then hold low until timeout
        rise_at(2000); fall_at(150); wait_us(10);
        rd(2'd2, d); chk("pre_to_status", d, 32'h11);
        wait_until(t_fall, 4990);
        rd(2'd2, d); chk("before_to", d, 32'h11);
        wait_until(t_fall, 5005);
        rd(2'd2, d); chk("timeout_status", d, 32'h02);
        rd(2'd0, d); chk_near("to_width", d, 150);
        rd(2'd1, d); chk_near("to_period", d, 2000);

        // Resume with an 1800 us period
        rise_now(); fall_at(150); rise_at(1800); wait_us(5);
        rd(2'd2, d); chk("resume_status", d, 32'h0B);
        rd(2'd1, d); chk_near("resume_period", d, 1800);
        wr(2'd2, 32'h2);
        rd(2'd2, d); chk("w1c_timeout", d, 32'h09);

        // Period beyond counter range saturates
        fall_at(150); rise_at(4500); wait_us(5);
        rd(2'd1, d); chk("sat_period", d, 32'd4095);
        fall_at(150); wait_us(5);
        rd(2'd0, d); chk_near("sat_width", d, 150);
        rd(2'd2, d); chk("sat_status", d, 32'h11);

        // Reset mid-HIGH, pin still high afterwards (partial pulse)
        rise_at(2000); wait_until(t_rise, 70);
        #3 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        rd(2'd0, d); chk("mid_rst_width", d, 32'd0);
        rd(2'd1, d); chk("mid_rst_period", d, 32'd0);
        rd(2'd2, d); chk("mid_rst_status", d, 32'd0);
        fall_at(110); wait_us(10);
        rd(2'd2, d); chk("partial_status", d, 32'd0);

        rise_now(); fall_at(100); wait_us(10);
        rd(2'd0, d); chk_near("p1_width", d, 100);
        rd(2'd2, d); chk("p1_status", d, 32'h11);
        rise_at(2000); fall_at(100); wait_us(10);
        rd(2'd0, d); chk_near("p2_width", d, 100);
        rd(2'd1, d); chk_near("p2_period", d, 2000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
